// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  localparam int IW = $clog2(NUM_REQ),
  localparam int BW = $clog2(MAX_BURST) + 1
) (
  input  logic                          i_sys_clk,
  input  logic                          i_sys_rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]            i_req_last,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_fifo_wren,
  output logic [DATA_WIDTH-1:0]         o_fifo_wdata,
  input  logic                          i_fifo_full,
  output logic [IW-1:0]                 o_grant_id,
  output logic                          o_busy
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nx;
  logic [IW-1:0] owner, owner_nx, owner_inc, rr_ptr, rr_nx, start, idx, win;
  logic [BW-1:0] cnt, cnt_nx;
  logic found, in_grant, burst_end;
  logic [DATA_WIDTH-1:0] slice [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
    assign slice[k] = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  assign owner_inc    = owner == IW'(NUM_REQ-1) ? '0 : owner + 1'b1;
  assign in_grant     = state == GRANT;
  assign o_req_ready  = in_grant && !i_fifo_full ? NUM_REQ'(1) << owner : '0;
  assign o_fifo_wren  = in_grant && i_req_valid[owner] && !i_fifo_full;
  assign o_fifo_wdata = in_grant ? slice[owner] : '0;
  assign o_grant_id   = owner;
  assign o_busy       = in_grant;
  assign burst_end    = o_fifo_wren && (i_req_last[owner] || cnt == BW'(MAX_BURST-1));

  // During a grant the search starts after the owner, so the owner is considered last
  always_comb begin
    start = in_grant ? owner_inc : rr_ptr;
    win   = '0;
    found = 1'b0;
    idx   = start;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && i_req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
      idx = idx == IW'(NUM_REQ-1) ? '0 : idx + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    rr_nx    = rr_ptr;
    cnt_nx   = cnt;
    if (!in_grant) begin
      state_nx = found ? GRANT : IDLE;
      owner_nx = found ? win : owner;
      cnt_nx   = '0;
    end else if (burst_end) begin
      rr_nx    = owner_inc;
      state_nx = found ? GRANT : IDLE;
      owner_nx = found ? win : owner;
      cnt_nx   = '0;
    end else begin
      cnt_nx   = o_fifo_wren ? cnt + 1'b1 : cnt;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nx;
      owner  <= owner_nx;
      rr_ptr <= rr_nx;
      cnt    <= cnt_nx;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: randomized producers against a rule-level arbitration model with a write scoreboard
module tb_fifo_wr_arbiter;
  localparam int N = 4, DW = 8, MB = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] v = '0, last = '0, ready;
  logic [N*DW-1:0] data = '0;
  logic wren, full = 1'b0, busy;
  logic [DW-1:0] wdata;
  logic [1:0] gid;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_req_valid(v), .i_req_data(data),
    .i_req_last(last), .o_req_ready(ready), .o_fifo_wren(wren), .o_fifo_wdata(wdata),
    .i_fifo_full(full), .o_grant_id(gid), .o_busy(busy));

  int total = 0, bad = 0;
  logic [9:0] expq [$];
  logic m_busy = 1'b0, exp_busy = 1'b0;
  logic [N-1:0] exp_ready = '0;
  int m_owner = 0, m_ptr = 0, m_cnt = 0;
  int sn [N], rem [N];
  int pv, pf, maxb;
  logic no_last;
  logic [N-1:0] mask;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int arb(input int s);
    for (int i = 0; i < N; i++) if (v[(s+i)%N]) return (s+i)%N;
    return -1;
  endfunction

  // One clock: drive producers, then predict this cycle's write and the owner for the next one
  task automatic cycle();
    int w;
    logic fin;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      v[k] = mask[k] && ($urandom_range(99) < pv);
      last[k] = !no_last && rem[k] == 1;
      data[k*DW +: DW] = 8'(k*64 + sn[k]%64);
    end
    full = $urandom_range(99) < pf;
    #1;
    exp_busy  = m_busy;
    exp_ready = (m_busy && !full) ? N'(1) << m_owner : '0;
    fin = 1'b0;
    if (m_busy && v[m_owner] && !full) begin
      expq.push_back({2'(m_owner), data[m_owner*DW +: DW]});
      m_cnt++;
      fin = last[m_owner] || m_cnt == MB;
      sn[m_owner]++;
      rem[m_owner]--;
      if (rem[m_owner] <= 0) rem[m_owner] = $urandom_range(1, maxb);
    end
    if (!m_busy) begin
      w = arb(m_ptr);
      if (w >= 0) begin m_busy = 1'b1; m_owner = w; m_cnt = 0; end
    end else if (fin) begin
      m_ptr = (m_owner + 1) % N;
      w = arb(m_ptr);
      if (w < 0) m_busy = 1'b0;
      else begin m_owner = w; m_cnt = 0; end
    end
  endtask

  task automatic run(input logic [N-1:0] m, input int p_v, input int p_f, input logic nl,
                     input int mx, input int cycles);
    mask = m; pv = p_v; pf = p_f; no_last = nl; maxb = mx;
    for (int k = 0; k < N; k++) rem[k] = $urandom_range(1, mx);
    repeat (cycles) cycle();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_wren"}, wren, 0);
    check({tag, "_wdata"}, wdata, 0);
    check({tag, "_gid"}, gid, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      #2;
      check("busy", busy, exp_busy);
      check("ready", ready, exp_ready);
      if (!exp_busy) check("idle_wdata", wdata, 0);
      if (wren) begin
        if (expq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_wren: got wren=1 data %0h want no write at %0t", wdata, $time);
        end else begin
          e = expq.pop_front();
          check("wdata", wdata, e[7:0]);
          check("grant_id", gid, e[9:8]);
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < N; k++) begin sn[k] = 0; rem[k] = 1; end
    repeat (3) @(negedge clk);
    #2 check_zero("reset");
    rst_n = 1'b1;
    run(4'b0100, 100, 0, 1'b0, 3, 12);
    run(4'hF, 100, 0, 1'b1, 1, 40);
    run(4'hF, 70, 20, 1'b0, 6, 400);
    run(4'b0010, 100, 0, 1'b0, 1, 30);
    run(4'b1001, 60, 0, 1'b0, 5, 200);
    run(4'b0010, 100, 40, 1'b0, 8, 100);
    run(4'hF, 90, 30, 1'b0, 8, 400);
    run(4'hF, 100, 0, 1'b1, 1, 7);
    #2 rst_n = 1'b0;
    v = '0; full = 1'b0;
    #1 check_zero("midrst");
    m_busy = 1'b0; m_ptr = 0; m_cnt = 0; m_owner = 0;
    exp_busy = 1'b0; exp_ready = '0;
    expq.delete();
    @(negedge clk) rst_n = 1'b1;
    run(4'hF, 100, 0, 1'b1, 1, 40);
    run(4'hF, 80, 15, 1'b0, 6, 300);
    run(4'h0, 0, 0, 1'b0, 1, 10);
    #3 check("drain", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
